if_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of instruction decode.
- Holds the PC and drives the instruction-memory address.
- Generates the immediate and PC+4, and predicts conditional branches and JAL.
- Registers instruction/IMM/PCplus/prediction into the IF/ID pipeline register consumed by decode.

---
 rtl/if_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, immediate generation, branch/JAL prediction, IF/ID register.
// Define IF_BHT_EN for a 2-bit dynamic BHT; otherwise branches use static backward-taken/forward-not-taken.
module if_stage #(
   parameter int              size      = 32,
   parameter int              BHT_DEPTH = 16,
   parameter logic [size-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [size-1:0] correct_pc_i,
   input  logic            upd_valid_i,
   input  logic [size-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [size-1:0] instruction_mem_i,
   output logic [size-1:0] imem_addr_o,
   output logic [size-1:0] instruction_o,
   output logic [size-1:0] IMM_o,
   output logic [size-1:0] PCplus_o,
   output logic            Predicted_MPC_o
);

   localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [size-1:0] pc_q, pc_d;
   logic [size-1:0] instr_q, instr_d;
   logic [size-1:0] imm_q, imm_d;
   logic [size-1:0] pcplus_q, pcplus_d;
   logic            pred_q, pred_d;

   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [31:0]     imm_32;
   logic [size-1:0] imm;
   logic [size-1:0] pc_plus4;
   logic [size-1:0] next_pc;
   logic            is_jal;
   logic            is_branch;
   logic            branch_taken;
   logic            pred_taken;

   assign instr  = instruction_mem_i[31:0];
   assign opcode = instr[6:0];

   always_comb begin
      imm_32 = '0;
      case (opcode)
         OP_LOAD, OP_ALUI, OP_JALR: imm_32 = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:                  imm_32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:                 imm_32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:          imm_32 = {instr[31:12], 12'b0};
         OP_JAL:                    imm_32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default:                   imm_32 = '0;
      endcase
   end

   assign imm       = size'($signed(imm_32));
   assign is_jal    = (opcode == OP_JAL);
   assign is_branch = (opcode == OP_BRANCH);

`ifdef IF_BHT_EN
   logic [1:0]       bht_q [BHT_DEPTH];
   logic [1:0]       bht_d [BHT_DEPTH];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] upd_idx;
   logic             unused_upd_bits;

   assign rd_idx          = pc_q[IDX_W+1:2];
   assign upd_idx         = upd_pc_i[IDX_W+1:2];
   assign unused_upd_bits = ^{upd_pc_i[size-1:IDX_W+2], upd_pc_i[1:0]};
   // Prediction reads bht_q, so a same-cycle update to the same entry is not yet visible.
   assign branch_taken    = bht_q[rd_idx][1];

   always_comb begin
      bht_d = bht_q;
      if (upd_valid_i) begin
         if (upd_taken_i && (bht_q[upd_idx] != 2'b11))
            bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
         else if (!upd_taken_i && (bht_q[upd_idx] != 2'b00))
            bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++)
            bht_q[i] <= 2'b01;
      end else begin
         bht_q <= bht_d;
      end
   end
`else
   logic unused_upd;

   assign unused_upd   = ^{upd_valid_i, upd_taken_i, upd_pc_i};
   assign branch_taken = imm_32[31];
`endif

   assign pred_taken = is_jal | (is_branch & branch_taken);
   assign pc_plus4   = pc_q + size'(4);
   assign next_pc    = pred_taken ? (pc_q + imm) : pc_plus4;

   // A flush also zeroes the whole IF/ID register, so decode sees an all-zero bubble.
   always_comb begin
      pc_d     = next_pc;
      instr_d  = instruction_mem_i;
      imm_d    = imm;
      pcplus_d = pc_plus4;
      pred_d   = pred_taken;
      if (flush) begin
         pc_d     = correct_pc_i;
         instr_d  = '0;
         imm_d    = '0;
         pcplus_d = '0;
         pred_d   = 1'b0;
      end else if (stall) begin
         pc_d     = pc_q;
         instr_d  = instr_q;
         imm_d    = imm_q;
         pcplus_d = pcplus_q;
         pred_d   = pred_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         imm_q    <= '0;
         pcplus_q <= '0;
         pred_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         imm_q    <= imm_d;
         pcplus_q <= pcplus_d;
         pred_q   <= pred_d;
      end
   end

   assign imem_addr_o     = pc_q;
   assign instruction_o   = instr_q;
   assign IMM_o           = imm_q;
   assign PCplus_o        = pcplus_q;
   assign Predicted_MPC_o = pred_q;

endmodule
